fb_mem_responder: RTL and testbench

Responder end of the engine-to-arbiter memory request interface: accepts write/read requests (address, data, byte enables, op) under an rts/rtr handshake, executes them in order against a 32-bit-wide frame-buffer word RAM, and returns read data on the broadcast bus with a one-cycle transfer strobe. Drawing engines such as the fill-rect engine connect to it directly in unit benches, and it serves as the memory back end behind the arbiter in the full design. A small request FIFO decouples acceptance from execution.

---
 rtl/fb_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_fb_mem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_mem_responder.sv
// fb_mem_responder: memory back end for the drawing engines. Requests are
// accepted under an rts/rtr handshake into a small FIFO, executed one per
// cycle in acceptance order against a byte-maskable frame-buffer word RAM,
// and read results are returned on the broadcast bus with a one-cycle strobe.
module fb_mem_responder #(
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int REQ_DEPTH      = 4,
    parameter int LOG2REQ_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic [31:0] arb_in_data,
    input  logic [15:0] arb_in_addr,
    input  logic [3:0]  arb_in_wben,
    input  logic        arb_in_op,
    input  logic        arb_in_rts,
    output logic        arb_out_rtr,
    output logic [31:0] arb_bcast_out_data,
    output logic        arb_bcast_out_xfc,
    output logic        mem_idle
);

    localparam int RAM_DEPTH = 1 << MEM_ADDR_WIDTH;
    localparam logic [LOG2REQ_DEPTH:0] FULL_COUNT = (LOG2REQ_DEPTH + 1)'(REQ_DEPTH);

    // One queued request exactly as presented on the request interface.
    typedef struct packed {
        logic        op;
        logic [3:0]  wben;
        logic [15:0] addr;
        logic [31:0] data;
    } req_t;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    req_t                   r_fifo [REQ_DEPTH];
    logic [LOG2REQ_DEPTH-1:0] r_wr_ptr;
    logic [LOG2REQ_DEPTH-1:0] r_rd_ptr;
    logic [LOG2REQ_DEPTH:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    req_t w_push_entry;
    req_t w_head;

    assign w_full   = (r_count == FULL_COUNT);
    assign w_empty  = (r_count == '0);
    // rtr depends only on occupancy so the requester never sees a
    // combinational path from its own rts.
    assign w_push   = arb_in_rts && !w_full;
    // Pop decision uses the registered count, so an entry written on this
    // edge cannot also be consumed on this edge.
    assign w_pop    = !w_empty;
    assign w_head   = r_fifo[r_rd_ptr];

    assign w_push_entry.op   = arb_in_op;
    assign w_push_entry.wben = arb_in_wben;
    assign w_push_entry.addr = arb_in_addr;
    assign w_push_entry.data = arb_in_data;

    // FIFO payload storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_push_entry;
        end
    end

    // FIFO pointers and occupancy; reset flushes every queued request.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Execute stage
    // ------------------------------------------------------------------
    logic                      w_oor;
    logic [MEM_ADDR_WIDTH-1:0] w_ram_idx;
    logic                      w_ram_we;
    logic                      w_ram_re;

    // Any set address bit above the implemented RAM range makes the access
    // out of range; with a full 16-bit RAM nothing is out of range.
    generate
        if (MEM_ADDR_WIDTH < 16) begin : g_oor
            assign w_oor = |w_head.addr[15:MEM_ADDR_WIDTH];
        end else begin : g_no_oor
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_ram_idx = w_head.addr[MEM_ADDR_WIDTH-1:0];
    assign w_ram_we  = w_pop && w_head.op && !w_oor;
    assign w_ram_re  = w_pop && !w_head.op;

    // Per-lane write strobes, one per byte of the RAM word.
    logic [3:0] w_lane_we;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_we[gi] = w_ram_we && w_head.wben[gi];
        end
    endgenerate

    // Frame-buffer word RAM with byte-lane writes and a registered read.
    // Contents survive reset by design.
    logic [31:0] r_ram [RAM_DEPTH];
    logic [31:0] r_ram_q;

    // RAM port: byte-masked write and synchronous read on the execute edge.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_lane_we[b]) begin
                r_ram[w_ram_idx][8*b +: 8] <= w_head.data[8*b +: 8];
            end
        end
        if (w_ram_re) begin
            r_ram_q <= r_ram[w_ram_idx];
        end
    end

    // ------------------------------------------------------------------
    // Read return pipeline
    // ------------------------------------------------------------------
    logic        r_rd_pending;
    logic        r_rd_oor;
    logic        r_xfc;
    logic [31:0] r_bcast_data;

    // Tracks a read that executed this cycle; reset discards it.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_rd_pending <= 1'b0;
            r_rd_oor     <= 1'b0;
        end else begin
            r_rd_pending <= w_ram_re;
            r_rd_oor     <= w_ram_re && w_oor;
        end
    end

    // Broadcast stage: one-cycle strobe, data held between strobes.
    // Out-of-range reads still strobe, but with zero data.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_xfc        <= 1'b0;
            r_bcast_data <= 32'h0000_0000;
        end else begin
            r_xfc <= r_rd_pending;
            if (r_rd_pending) begin
                r_bcast_data <= r_rd_oor ? 32'h0000_0000 : r_ram_q;
            end
        end
    end

    assign arb_out_rtr        = !w_full;
    assign arb_bcast_out_xfc  = r_xfc;
    assign arb_bcast_out_data = r_bcast_data;
    assign mem_idle           = w_empty && !r_rd_pending && !r_xfc;

endmodule

// File: tb/tb_fb_mem_responder.sv
// Testbench for fb_mem_responder: directed scenarios plus random traffic,
// with expected read returns (data and strobe cycle) queued at issue time
// and checked by an independent monitor on the broadcast bus.
module tb_fb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data;
    logic [15:0] in_addr;
    logic [3:0]  in_wben;
    logic        in_op;
    logic        in_rts;
    logic        rtr;
    logic [31:0] bdata;
    logic        xfc;
    logic        idle;

    always #5 clk = ~clk;

    fb_mem_responder #(
        .MEM_ADDR_WIDTH(12),
        .REQ_DEPTH(4),
        .LOG2REQ_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst_(rst_n),
        .arb_in_data(in_data),
        .arb_in_addr(in_addr),
        .arb_in_wben(in_wben),
        .arb_in_op(in_op),
        .arb_in_rts(in_rts),
        .arb_out_rtr(rtr),
        .arb_bcast_out_data(bdata),
        .arb_bcast_out_xfc(xfc),
        .mem_idle(idle)
    );

    int n_err = 0;
    int n_chk = 0;

    // Rising-edge counter: sampled at a falling edge it names the edge just past.
    int pcnt = 0;
    always @(posedge clk) pcnt <= pcnt + 1;

    // Reference model: word memory, in-order service timeline, expected returns.
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t        sb_q[$];
    logic [31:0] mem_m [4096];
    int          last_e = 0;
    int          busy_until = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, pcnt);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && xfc === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_xfc: got strobe with data %h at edge %0d, expected none", bdata, pcnt);
            end else begin
                e = sb_q.pop_front();
                $display("xfc edge %0d data %h", pcnt, bdata);
                check("xfc_data", bdata, e.data);
                check("xfc_edge", pcnt, e.cyc);
            end
        end
    end

    // One cycle of stimulus. Requests are served in order one per cycle,
    // at the earliest one edge after acceptance; a read strobes one edge
    // after it is served.
    task automatic req(input bit v, input bit op, input logic [15:0] addr,
                       input logic [31:0] data, input logic [3:0] wben);
        int a_edge;
        int e_edge;
        bit oor;
        exp_t e;
        @(negedge clk);
        check("mem_idle", idle, (pcnt > busy_until) ? 32'd1 : 32'd0);
        check("rtr", rtr, 32'd1);
        in_rts  = v;
        in_op   = op;
        in_addr = addr;
        in_data = data;
        in_wben = wben;
        if (v && rtr) begin
            a_edge = pcnt + 1;
            e_edge = (a_edge + 1 > last_e + 1) ? a_edge + 1 : last_e + 1;
            last_e = e_edge;
            oor = (addr[15:12] != 4'h0);
            if (op) begin
                if (!oor) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wben[b]) mem_m[addr[11:0]][8*b +: 8] = data[8*b +: 8];
                    end
                end
                if (e_edge - 1 > busy_until) busy_until = e_edge - 1;
            end else begin
                e.data = oor ? 32'h0 : mem_m[addr[11:0]];
                e.cyc  = e_edge + 1;
                sb_q.push_back(e);
                if (e_edge + 1 > busy_until) busy_until = e_edge + 1;
            end
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            req(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
            done = (sb_q.size() == 0) && (pcnt > busy_until);
        end
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_timeout: got %0d outstanding reads, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        logic [15:0] ra;
        in_rts  = 1'b1;
        in_op   = 1'b0;
        in_addr = 16'h0;
        in_data = 32'h0;
        in_wben = 4'h0;

        // Reset held with rts asserted: nothing may be accepted.
        repeat (3) @(negedge clk);
        check("reset_rtr", rtr, 32'd1);
        check("reset_xfc", xfc, 32'd0);
        check("reset_data", bdata, 32'h0);
        check("reset_idle", idle, 32'd1);
        in_rts = 1'b0;
        rst_n  = 1'b1;
        repeat (3) req(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);

        // Give every word used later a known value.
        for (int a = 0; a < 48; a++) req(1'b1, 1'b1, 16'(a), $urandom, 4'hF);
        drain();

        // Write then read on the next cycle.
        req(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
        req(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0);
        drain();

        // Byte-enable merge.
        req(1'b1, 1'b1, 16'h0021, 32'h11223344, 4'hF);
        req(1'b1, 1'b1, 16'h0021, 32'hAABBCCDD, 4'b0101);
        req(1'b1, 1'b0, 16'h0021, 32'h0, 4'h0);
        drain();
        check("byte_merge_model", mem_m[12'h021], 32'h11BB33DD);

        // Streaming reads of addresses 0..7 holding their own address.
        for (int a = 0; a < 8; a++) req(1'b1, 1'b1, 16'(a), 32'(a), 4'hF);
        drain();
        for (int a = 0; a < 8; a++) req(1'b1, 1'b0, 16'(a), 32'h0, 4'h0);
        drain();

        // Out-of-range write is dropped, out-of-range read returns zero.
        req(1'b1, 1'b1, 16'h1005, 32'hFFFFFFFF, 4'hF);
        req(1'b1, 1'b0, 16'h1005, 32'h0, 4'h0);
        req(1'b1, 1'b0, 16'h0005, 32'h0, 4'h0);
        drain();

        // Reset in the middle of three reads.
        req(1'b1, 1'b0, 16'h0001, 32'h0, 4'h0);
        req(1'b1, 1'b0, 16'h0002, 32'h0, 4'h0);
        req(1'b1, 1'b0, 16'h0003, 32'h0, 4'h0);
        @(negedge clk);
        in_rts = 1'b0;
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        last_e = 0;
        busy_until = -1;
        repeat (2) begin
            @(negedge clk);
            check("midreset_xfc", xfc, 32'd0);
            check("midreset_idle", idle, 32'd1);
        end
        rst_n = 1'b1;
        repeat (4) req(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        req(1'b1, 1'b0, 16'h0003, 32'h0, 4'h0);
        drain();

        // Random mixed traffic with idle gaps and out-of-range addresses.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 2) ra = {4'($urandom_range(1, 15)), 12'($urandom_range(0, 47))};
            else ra = 16'($urandom_range(0, 47));
            req(($urandom_range(0, 9) < 7), 1'($urandom), ra, $urandom, 4'($urandom));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
